kbd_shift_receiver: RTL and testbench

Serial keyboard receiver for the IBM PC system board, replacing the LS322-based keyboard shift logic. Samples the keyboard clock/data lines and assembles one start bit plus an 8-bit scan code, LSB first. Raises the keyboard interrupt and presents the code on a tri-state byte output. That output feeds the downstream LS244 data-bus buffer / 8255 port A path.

---
 rtl/kbd_shift_receiver.sv | 140 ++++++++++++++
 tb/tb_kbd_shift_receiver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_shift_receiver.sv
// kbd_shift_receiver: serial keyboard receiver for the PC system board.
// Samples the keyboard clock/data lines and assembles a start bit plus a
// DATA_BITS scan code (LSB first). It raises irq and holds the keyboard
// clock low until the code is cleared. The code is presented on a
// tri-state byte output.
module kbd_shift_receiver #(
  parameter int DATA_BITS      = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 kbd_clk,
  input  logic                 kbd_data,
  input  logic                 clear,
  input  logic                 oe_n,
  output logic [DATA_BITS-1:0] data,
  output logic                 irq,
  output logic                 kbd_clk_hold_n,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_p0, state_n;
  logic [SYNC_STAGES-1:0] clk_sync_p0, data_sync_p0;
  logic                   clk_dly_p1;
  logic [DATA_BITS-1:0]   sreg_p0, sreg_n;
  logic [CW-1:0]          cnt_p0, cnt_n, cnt_inc;
  logic [TW-1:0]          tmo_p0, tmo_n, tmo_inc;
  logic                   clk_s, din, fall;

  // Stage p0: bring both raw keyboard lines into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_p0  <= '1;
      data_sync_p0 <= '1;
    end else begin
      clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], kbd_clk};
      data_sync_p0 <= {data_sync_p0[SYNC_STAGES-2:0], kbd_data};
    end
  end

  assign clk_s = clk_sync_p0[SYNC_STAGES-1];
  assign din   = data_sync_p0[SYNC_STAGES-1];

  // Stage p1: one-cycle delayed synchronized clock for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_dly_p1 <= 1'b1;
    else          clk_dly_p1 <= clk_s;
  end

  // The data bit paired with an edge is the synchronized data in that same cycle
  assign fall    = clk_dly_p1 & ~clk_s;
  assign cnt_inc = cnt_p0 + CW'(1);
  assign tmo_inc = tmo_p0 + TW'(1);

  // Receiver state, shift register, counters and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0       <= IDLE;
      sreg_p0        <= '0;
      cnt_p0         <= '0;
      tmo_p0         <= '0;
      irq            <= 1'b0;
      kbd_clk_hold_n <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state_p0       <= state_n;
      sreg_p0        <= sreg_n;
      cnt_p0         <= cnt_n;
      tmo_p0         <= tmo_n;
      irq            <= (state_n == FULL);
      kbd_clk_hold_n <= (state_n != FULL);
      busy           <= (state_n == SHIFT);
    end
  end

  // Next-state logic: clear overrides everything, including a coincident edge
  always_comb begin
    state_n = state_p0;
    sreg_n  = sreg_p0;
    cnt_n   = cnt_p0;
    tmo_n   = tmo_p0;
    if (clear) begin
      state_n = IDLE;
      sreg_n  = '0;
      cnt_n   = '0;
      tmo_n   = '0;
    end else begin
      unique case (state_p0)
        IDLE: begin
          tmo_n = '0;
          // A low data bit on an edge is line noise, not a start bit
          if (fall && din) begin
            state_n = SHIFT;
            sreg_n  = '0;
            cnt_n   = '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            sreg_n = {din, sreg_p0[DATA_BITS-1:1]};
            cnt_n  = cnt_inc;
            tmo_n  = '0;
            if (cnt_inc == CW'(DATA_BITS)) state_n = FULL;
          end else if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
            // Keyboard went quiet mid-frame: drop the partial code
            state_n = IDLE;
            sreg_n  = '0;
            cnt_n   = '0;
            tmo_n   = '0;
          end else begin
            tmo_n = tmo_inc;
          end
        end
        FULL: begin
          tmo_n = '0;
        end
        default: begin
          state_n = IDLE;
          sreg_n  = '0;
          cnt_n   = '0;
          tmo_n   = '0;
        end
      endcase
    end
  end

  // Bus output follows the shift register directly, including partial frames
  assign data = oe_n ? {DATA_BITS{1'bz}} : sreg_p0;

endmodule

// File: tb/tb_kbd_shift_receiver.sv
// Testbench for kbd_shift_receiver: directed scenarios plus random frames,
// with expected scan codes queued at issue and checked when irq rises.
module tb_kbd_shift_receiver;

  localparam int DATA_BITS = 8;
  localparam int TMO       = 32;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       kbd_clk;
  logic       kbd_data;
  logic       clear;
  logic       oe_n;
  wire  [7:0] data;
  logic       irq;
  logic       kbd_clk_hold_n;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic       irq_prev = 1'b0;

  kbd_shift_receiver #(
    .DATA_BITS(DATA_BITS),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .kbd_clk(kbd_clk),
    .kbd_data(kbd_data),
    .clear(clear),
    .oe_n(oe_n),
    .data(data),
    .irq(irq),
    .kbd_clk_hold_n(kbd_clk_hold_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // High-Z reads as z; a two-state simulator folds an undriven net to 0
  task automatic check_hiz(input string name);
    n_checks++;
    if (data === 8'bzzzzzzzz || data === 8'h00) n_pass++;
    else $display("FAIL %s: got %h, expected zz", name, data);
  endtask

  // Reference model: a frame is a start bit of 1 followed by bits sent LSB first
  function automatic logic [7:0] model_code(input logic bits[$]);
    int v = 0;
    for (int i = 0; i < DATA_BITS; i++) v += int'(bits[i]) * (1 << i);
    return v[7:0];
  endfunction

  // Monitor: every rising irq is a presented code; compare with the oldest expected
  always @(negedge clk) begin
    if (irq && !irq_prev) begin
      if (exp_q.size() == 0) begin
        check8("irq_unexpected", data, 8'hxx);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check8("rx_code", data, e);
        check8("rx_hold_n", {7'd0, kbd_clk_hold_n}, 8'd0);
        check8("rx_busy", {7'd0, busy}, 8'd0);
      end
    end
    irq_prev = irq;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic b);
    kbd_data = b;
    wait_neg($urandom_range(7, 4));
    kbd_clk = 1'b0;
    wait_neg($urandom_range(7, 4));
    kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code);
    logic bits[$];
    for (int i = 0; i < DATA_BITS; i++) bits.push_back(code[i]);
    exp_q.push_back(model_code(bits));
    pulse(1'b1);
    for (int i = 0; i < DATA_BITS; i++) pulse(bits[i]);
    wait_neg(4);
  endtask

  task automatic wait_irq(input string name);
    int k = 0;
    while (!irq && k < 200) begin
      @(negedge clk);
      k++;
    end
    check8(name, {7'd0, irq}, 8'd1);
    wait_neg(2);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_neg(2);
  endtask

  initial begin
    reset_n  = 1'b0;
    kbd_clk  = 1'b1;
    kbd_data = 1'b1;
    clear    = 1'b0;
    oe_n     = 1'b0;
    #12;
    check8("rst_data", data, 8'h00);
    check8("rst_irq", {7'd0, irq}, 8'd0);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    check8("rst_hold_n", {7'd0, kbd_clk_hold_n}, 8'd1);
    oe_n = 1'b1;
    #1;
    check_hiz("rst_hiz");
    oe_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_neg(5);

    // Scan code 1Ch, then output-enable toggle while pending
    send_frame(8'h1C);
    wait_irq("irq_1c");
    check8("full_hold_n", {7'd0, kbd_clk_hold_n}, 8'd0);
    check8("full_busy", {7'd0, busy}, 8'd0);
    oe_n = 1'b1;
    #1;
    check_hiz("full_hiz");
    check8("full_irq_oe1", {7'd0, irq}, 8'd1);
    @(negedge clk);
    oe_n = 1'b0;

    // Keyboard clock activity while FULL is ignored
    for (int i = 0; i < 10; i++) pulse(1'($urandom_range(1, 0)));
    wait_neg(6);
    check8("full_hold_data", data, 8'h1C);
    check8("full_hold_irq", {7'd0, irq}, 8'd1);
    do_clear();
    check8("clr_irq", {7'd0, irq}, 8'd0);
    check8("clr_data", data, 8'h00);
    check8("clr_hold_n", {7'd0, kbd_clk_hold_n}, 8'd1);
    send_frame(8'hAA);
    wait_irq("irq_aa");
    do_clear();

    // Noise edge in IDLE, then a good frame
    pulse(1'b0);
    wait_neg(6);
    check8("noise_busy", {7'd0, busy}, 8'd0);
    send_frame(8'h55);
    wait_irq("irq_55");
    do_clear();

    // Abandoned frame: start plus three bits, then silence past the timeout
    pulse(1'b1);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
    wait_neg(2);
    check8("tmo_busy_before", {7'd0, busy}, 8'd1);
    wait_neg(TMO + 10);
    check8("tmo_busy", {7'd0, busy}, 8'd0);
    check8("tmo_irq", {7'd0, irq}, 8'd0);
    check8("tmo_data", data, 8'h00);
    send_frame(8'h3A);
    wait_irq("irq_3a");
    do_clear();

    // Asynchronous reset mid-frame after five data bits of 1
    pulse(1'b1);
    for (int i = 0; i < 5; i++) pulse(1'b1);
    wait_neg(2);
    check8("mid_busy", {7'd0, busy}, 8'd1);
    check8("mid_partial", data, 8'hF8);
    #3;
    reset_n = 1'b0;
    #1;
    check8("arst_data", data, 8'h00);
    check8("arst_busy", {7'd0, busy}, 8'd0);
    check8("arst_irq", {7'd0, irq}, 8'd0);
    check8("arst_hold_n", {7'd0, kbd_clk_hold_n}, 8'd1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_neg(4);

    // Clear held across a start-bit falling edge discards that edge
    kbd_data = 1'b1;
    wait_neg(4);
    clear = 1'b1;
    @(negedge clk);
    kbd_clk = 1'b0;
    wait_neg(6);
    clear = 1'b0;
    wait_neg(4);
    check8("clr_edge_busy", {7'd0, busy}, 8'd0);
    kbd_clk = 1'b1;
    wait_neg(6);
    check8("clr_edge_busy2", {7'd0, busy}, 8'd0);
    check8("clr_edge_data", data, 8'h00);

    // Random frames, optionally preceded by noise edges
    for (int n = 0; n < 20; n++) begin
      logic [7:0] code;
      code = 8'($urandom_range(255, 0));
      if ($urandom_range(1, 0) == 1) begin
        pulse(1'b0);
        wait_neg(3);
      end
      send_frame(code);
      wait_irq("irq_rand");
      if ($urandom_range(1, 0) == 1) pulse(1'($urandom_range(1, 0)));
      do_clear();
    end

    wait_neg(4);
    check8("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
